// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with a 2-flop input synchroniser, start-edge
// detection and a mid-bit baud counter. It supports 5..9 data bits, optional
// odd/even parity and 1 or 2 stop bits. Each received word is held in a
// valid/ready register together with its framing and parity flags.
module uart_rx_param #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_s_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  logic w_s;
  logic w_start;
  logic w_tick;
  logic w_last_stop;
  logic w_frm_final;
  logic w_par_exp;
  logic w_take;

  assign w_s         = r_sync2;
  assign w_start     = (r_state == S_IDLE) && r_s_prev && !w_s;
  assign w_tick      = (r_state != S_IDLE) && (r_cnt == '0);
  assign w_last_stop = (r_state == S_STOP) && w_tick && (r_stop_cnt == LAST_STOP);
  // The last stop sample is folded in here so the flag is ready on the deliver edge.
  assign w_frm_final = r_frm_err | ~w_s;
  assign w_par_exp   = (^r_shift) ^ PAR_ODD;
  assign w_take      = r_rx_valid & rx_ready;

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign overrun_err = r_overrun;
  assign rx_busy     = r_busy;

  // Synchronise the serial line and keep its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_s_prev <= 1'b1;
    end else begin
      r_sync1  <= rx_pin_in;
      r_sync2  <= r_sync1;
      r_s_prev <= r_sync2;
    end
  end

  // Baud counter: half a bit to the first tick after start, then one bit per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= CNT_HALF;
    end else if (w_tick) begin
      r_cnt <= CNT_FULL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Frame FSM: start check, data shift, parity check and stop sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_s) begin
              // Line back high at mid-start: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_DATA;
              r_bit_cnt  <= '0;
              r_stop_cnt <= 1'b0;
              r_par_err  <= 1'b0;
              r_frm_err  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_err <= (w_s != w_par_exp);
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (!w_s) begin
              r_frm_err <= 1'b1;
            end
            if (w_last_stop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_take) begin
        r_rx_valid <= 1'b0;
      end
      if (w_last_stop) begin
        // A word consumed in this same cycle frees the slot for the new one.
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_frame_err  <= w_frm_final;
          r_parity_err <= r_par_err;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: directed 8N1 and 7E2 scenarios followed by a
// randomized sweep over 24 parameter sets running side by side.
module tb_uart_rx_param;

  localparam int NCFG    = 24;
  localparam int NFRAMES = 200;
  localparam int DIV     = 16;
  localparam int BUDGET  = 60000;

  logic clk;
  logic rst;

  // Directed DUT, 8N1.
  logic       m_line, m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_fe, m_pe, m_ovr, m_busy;

  // Directed DUT, 7 data bits, even parity, 2 stop bits.
  logic       p_line, p_ready;
  logic [6:0] p_data;
  logic       p_valid, p_fe, p_pe, p_ovr, p_busy;

  // Sweep DUTs.
  logic [NCFG-1:0] sw_line;
  logic [8:0]      sw_data [NCFG];
  logic [NCFG-1:0] sw_valid, sw_fe, sw_pe, sw_ovr, sw_busy;

  int checks;
  int errors;
  int seen_cyc;
  int ovr_cnt;
  int busy_seen;

  // Sweep bookkeeping.
  logic [15:0] sw_fb   [NCFG];
  logic [8:0]  sw_exp  [NCFG][8];
  int          sw_pos  [NCFG];
  int          sw_sub  [NCFG];
  int          sw_n    [NCFG];
  int          sw_gap  [NCFG];
  int          sw_sent [NCFG];
  int          sw_rcv  [NCFG];
  int          sw_wr   [NCFG];
  int          sw_rd   [NCFG];
  bit          sw_in   [NCFG];
  bit          sw_ovr_seen [NCFG];

  function automatic int cfg_db(input int k);
    return (k % 2 == 1) ? 9 : 5;
  endfunction
  function automatic int cfg_par(input int k);
    return (k / 2) % 3;
  endfunction
  function automatic int cfg_st(input int k);
    return (k / 6) % 2 + 1;
  endfunction
  function automatic int cfg_div(input int k);
    return (k / 12 == 1) ? 17 : 4;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_m (
    .clk(clk), .rst(rst), .rx_pin_in(m_line), .rx_data(m_data), .rx_valid(m_valid),
    .rx_ready(m_ready), .frame_err(m_fe), .parity_err(m_pe), .overrun_err(m_ovr),
    .rx_busy(m_busy)
  );

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_p (
    .clk(clk), .rst(rst), .rx_pin_in(p_line), .rx_data(p_data), .rx_valid(p_valid),
    .rx_ready(p_ready), .frame_err(p_fe), .parity_err(p_pe), .overrun_err(p_ovr),
    .rx_busy(p_busy)
  );

  for (genvar k = 0; k < NCFG; k++) begin : g_sw
    localparam int unsigned DB = (k % 2 == 1) ? 9 : 5;
    localparam int unsigned PB = (k / 2) % 3;
    localparam int unsigned SB = (k / 6) % 2 + 1;
    localparam int unsigned CD = (k / 12 == 1) ? 17 : 4;
    logic [DB-1:0] w_d;
    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PB), .STOP_BITS(SB)) u_dut (
      .clk(clk), .rst(rst), .rx_pin_in(sw_line[k]), .rx_data(w_d), .rx_valid(sw_valid[k]),
      .rx_ready(1'b1), .frame_err(sw_fe[k]), .parity_err(sw_pe[k]), .overrun_err(sw_ovr[k]),
      .rx_busy(sw_busy[k])
    );
    assign sw_data[k] = 9'(w_d);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line-level frame: start 0, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] build_bits(input logic [8:0] data, input int db, input int par,
                                             input bit flip, input bit stop_lo, input int st);
    logic [15:0] b;
    int          idx;
    bit          pb;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < db; i++) b[1 + i] = data[i];
    idx = 1 + db;
    if (par != 0) begin
      // Odd: total ones including the parity bit is odd; even: total is even.
      pb = (par == 1) ? ($countones(data) % 2 == 0) : ($countones(data) % 2 == 1);
      b[idx] = pb ^ flip;
      idx++;
    end
    for (int s = 0; s < st; s++) begin
      b[idx] = ~stop_lo;
      idx++;
    end
    return b;
  endfunction

  function automatic int frame_len(input int db, input int par, input int st);
    return 1 + db + ((par != 0) ? 1 : 0) + st;
  endfunction

  task automatic drive_line(input int sel, input logic v);
    if (sel == 0) m_line = v;
    else p_line = v;
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel == 0) m_ready = v;
    else p_ready = v;
  endtask

  // Drive a frame bit by bit; record first cycle with valid high and overrun pulses.
  task automatic send_frame(input int sel, input logic [15:0] bits, input int n, input int ready_cyc);
    int   cyc;
    logic v, o, b;
    cyc       = 0;
    seen_cyc  = -1;
    ovr_cnt   = 0;
    busy_seen = 0;
    set_ready(sel, 1'(cyc == ready_cyc));
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < DIV; c++) begin
        drive_line(sel, bits[i]);
        @(negedge clk);
        cyc++;
        v = (sel == 0) ? m_valid : p_valid;
        o = (sel == 0) ? m_ovr   : p_ovr;
        b = (sel == 0) ? m_busy  : p_busy;
        if (v && seen_cyc < 0) seen_cyc = cyc;
        if (o) ovr_cnt++;
        if (b) busy_seen = 1;
        set_ready(sel, 1'(cyc == ready_cyc));
      end
    end
  endtask

  task automatic consume(input int sel);
    set_ready(sel, 1'b1);
    @(negedge clk);
    set_ready(sel, 1'b0);
  endtask

  task automatic idle_cycles(input int sel, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      drive_line(sel, v);
      @(negedge clk);
      if (((sel == 0) ? m_busy : p_busy) == 1'b1) busy_seen = 1;
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic [8:0]  d;
    int          cyc;
    bit          done;
    string       tag;

    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    m_line  = 1'b1;
    p_line  = 1'b1;
    m_ready = 1'b0;
    p_ready = 1'b0;
    sw_line = '1;
    repeat (3) @(negedge clk);

    check("reset_data",    32'(m_data),  0);
    check("reset_valid",   32'(m_valid), 0);
    check("reset_fe",      32'(m_fe),    0);
    check("reset_pe",      32'(m_pe),    0);
    check("reset_ovr",     32'(m_ovr),   0);
    check("reset_busy",    32'(m_busy),  0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic 8N1 with exact deliver latency and handshake.
    bits = build_bits(9'h0A5, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 10, -1);
    check("a5_latency", 32'(seen_cyc), 32'(2 + DIV / 2 + 9 * DIV + 1));
    check("a5_data",    32'(m_data),   32'h0A5);
    check("a5_fe",      32'(m_fe),     0);
    check("a5_pe",      32'(m_pe),     0);
    idle_cycles(0, 1'b1, 6);
    check("a5_hold_valid", 32'(m_valid), 1);
    consume(0);
    check("a5_valid_drop", 32'(m_valid), 0);
    check("a5_busy_idle",  32'(m_busy),  0);

    // 7E2: good parity then flipped parity bit.
    bits = build_bits(9'h035, 7, 2, 1'b0, 1'b0, 2);
    send_frame(1, bits, frame_len(7, 2, 2), -1);
    check("e7_valid", 32'(p_valid), 1);
    check("e7_data",  32'(p_data),  32'h35);
    check("e7_pe",    32'(p_pe),    0);
    check("e7_fe",    32'(p_fe),    0);
    consume(1);
    bits = build_bits(9'h035, 7, 2, 1'b1, 1'b0, 2);
    send_frame(1, bits, frame_len(7, 2, 2), -1);
    check("e7bad_data", 32'(p_data), 32'h35);
    check("e7bad_pe",   32'(p_pe),   1);
    check("e7bad_fe",   32'(p_fe),   0);
    consume(1);

    // Framing error with the line then stuck low, then a clean frame.
    bits = build_bits(9'h03C, 8, 0, 1'b0, 1'b1, 1);
    send_frame(0, bits, 10, -1);
    check("fe_valid", 32'(m_valid), 1);
    check("fe_data",  32'(m_data),  32'h3C);
    check("fe_flag",  32'(m_fe),    1);
    check("fe_pe",    32'(m_pe),    0);
    consume(0);
    idle_cycles(0, 1'b0, 3 * DIV);
    check("low_hold_busy",  32'(m_busy),  0);
    check("low_hold_valid", 32'(m_valid), 0);
    idle_cycles(0, 1'b1, DIV);
    bits = build_bits(9'h081, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 10, -1);
    check("after_fe_data", 32'(m_data), 32'h81);
    check("after_fe_fe",   32'(m_fe),   0);
    consume(0);

    // Short low glitch is a false start.
    busy_seen = 0;
    idle_cycles(0, 1'b0, 5);
    idle_cycles(0, 1'b1, 3 * DIV);
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy",      32'(m_busy),    0);
    check("glitch_valid",     32'(m_valid),   0);

    // Overrun, then ready exactly in the deliver cycle.
    bits = build_bits(9'h011, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 10, -1);
    check("ovr_first_data", 32'(m_data), 32'h11);
    bits = build_bits(9'h022, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 10, -1);
    check("ovr_pulses", 32'(ovr_cnt), 1);
    check("ovr_keep",   32'(m_data),  32'h11);
    check("ovr_valid",  32'(m_valid), 1);
    bits = build_bits(9'h033, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 10, 2 + DIV / 2 + 9 * DIV);
    check("same_cycle_data",  32'(m_data),  32'h33);
    check("same_cycle_valid", 32'(m_valid), 1);
    check("same_cycle_ovr",   32'(ovr_cnt), 0);

    // Reset during data bit 4 of 0xFF, with the 0x33 word still pending.
    bits = build_bits(9'h0FF, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 5, -1);
    idle_cycles(0, 1'b1, DIV / 2);
    check("pre_rst_busy", 32'(m_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_data",  32'(m_data),  0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_fe",    32'(m_fe),    0);
    check("rst_pe",    32'(m_pe),    0);
    check("rst_ovr",   32'(m_ovr),   0);
    check("rst_busy",  32'(m_busy),  0);
    rst = 1'b0;
    idle_cycles(0, 1'b1, 6 * DIV);
    check("post_rst_valid", 32'(m_valid), 0);
    bits = build_bits(9'h05A, 8, 0, 1'b0, 1'b0, 1);
    send_frame(0, bits, 10, -1);
    check("post_rst_data", 32'(m_data), 32'h5A);
    check("post_rst_fe",   32'(m_fe),   0);
    consume(0);

    // Parameter sweep: random frames on every configuration at once.
    for (int k = 0; k < NCFG; k++) begin
      sw_sent[k]     = 0;
      sw_rcv[k]      = 0;
      sw_wr[k]       = 0;
      sw_rd[k]       = 0;
      sw_in[k]       = 1'b0;
      sw_gap[k]      = $urandom_range(0, 5);
      sw_ovr_seen[k] = 1'b0;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < BUDGET) begin
      for (int k = 0; k < NCFG; k++) begin
        if (sw_ovr[k]) sw_ovr_seen[k] = 1'b1;
        if (sw_valid[k]) begin
          tag = $sformatf("sweep%0d_pending", k);
          check(tag, 32'(sw_wr[k] > sw_rd[k]), 1);
          if (sw_wr[k] > sw_rd[k]) begin
            tag = $sformatf("sweep%0d_word%0d", k, sw_rd[k]);
            check(tag, 32'({sw_fe[k], sw_pe[k], sw_data[k]}), 32'({2'b00, sw_exp[k][sw_rd[k] % 8]}));
            sw_rd[k]++;
          end
          sw_rcv[k]++;
        end
      end
      for (int k = 0; k < NCFG; k++) begin
        if (!sw_in[k] && sw_gap[k] == 0 && sw_sent[k] < NFRAMES) begin
          d = 9'($urandom) & 9'((1 << cfg_db(k)) - 1);
          sw_fb[k] = build_bits(d, cfg_db(k), cfg_par(k), 1'b0, 1'b0, cfg_st(k));
          sw_n[k]  = frame_len(cfg_db(k), cfg_par(k), cfg_st(k));
          sw_exp[k][sw_wr[k] % 8] = d;
          sw_wr[k]++;
          sw_sent[k]++;
          sw_in[k]  = 1'b1;
          sw_pos[k] = 0;
          sw_sub[k] = 0;
        end
        if (sw_in[k]) begin
          sw_line[k] = sw_fb[k][sw_pos[k]];
          sw_sub[k]++;
          if (sw_sub[k] == cfg_div(k)) begin
            sw_sub[k] = 0;
            sw_pos[k]++;
            if (sw_pos[k] == sw_n[k]) begin
              sw_in[k]  = 1'b0;
              sw_gap[k] = $urandom_range(0, 3);
            end
          end
        end else begin
          sw_line[k] = 1'b1;
          if (sw_gap[k] > 0) sw_gap[k]--;
        end
      end
      @(negedge clk);
      cyc++;
      done = 1'b1;
      for (int k = 0; k < NCFG; k++) begin
        if (sw_sent[k] < NFRAMES || sw_rcv[k] < NFRAMES) done = 1'b0;
      end
    end
    check("sweep_done_in_budget", 32'(done), 1);
    repeat (40) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      tag = $sformatf("sweep%0d_count", k);
      check(tag, 32'(sw_rcv[k]), 32'(NFRAMES));
      tag = $sformatf("sweep%0d_overrun", k);
      check(tag, 32'(sw_ovr_seen[k]), 0);
      tag = $sformatf("sweep%0d_busy", k);
      check(tag, 32'(sw_busy[k]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
